// File: rtl/mem_pkg.sv
// Shared definitions for the 6502 memory master: FSM state encoding and CPU vector addresses.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RD_LO = 2'd2,
        RD_HI = 2'd3
    } mem_master_state_t;

    localparam logic [15:0] NMI_VEC = 16'hFFFA;
    localparam logic [15:0] RST_VEC = 16'hFFFC;
    localparam logic [15:0] IRQ_VEC = 16'hFFFE;

endpackage

// File: rtl/mem_master.sv
// Bus initiator between the 6502 core and the behavioural memory: byte read/write, 16-bit word read.
// Optional feature macro: MEM_MASTER_PAGEWRAP_EN (word-read high byte wraps inside the 256-byte page).
module mem_master
    import mem_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               resetn,
    // Request accepted on the rising edge where req_valid && req_ready; fields latched there.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic               req_word,
    input  logic               req_pagewrap,
    input  logic [DEPTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               mem_enable,
    output logic               mem_wr_enable,
    output logic [DEPTH-1:0]   mem_address,
    output logic [WIDTH-1:0]   mem_wr_data,
    input  logic [WIDTH-1:0]   mem_rd_data
);

    localparam int CW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LATENCY);

    mem_master_state_t r_state, w_state_next;
    logic [CW-1:0]      r_cnt, w_cnt_next;
    logic               r_word, w_word_next;
    logic [DEPTH-1:0]   r_hi_addr, w_hi_addr_next, w_hi_addr_calc;

    logic               r_req_ready, w_req_ready_next;
    logic               r_rsp_valid, w_rsp_valid_next;
    logic [2*WIDTH-1:0] r_rsp_data, w_rsp_data_next;
    logic               r_mem_enable, w_mem_enable_next;
    logic               r_mem_wr_enable, w_mem_wr_enable_next;
    logic [DEPTH-1:0]   r_mem_address, w_mem_address_next;
    logic [WIDTH-1:0]   r_mem_wr_data, w_mem_wr_data_next;

    logic               w_accept;
    assign w_accept = req_valid && r_req_ready;

    // High-byte address is resolved at acceptance so later req_* changes cannot leak in.
`ifdef MEM_MASTER_PAGEWRAP_EN
    always_comb begin
        w_hi_addr_calc = req_addr + DEPTH'(1);
        if (req_pagewrap)
            w_hi_addr_calc = {req_addr[DEPTH-1:8], req_addr[7:0] + 8'd1};
    end
`else
    logic w_unused_pagewrap;
    assign w_unused_pagewrap = req_pagewrap;
    always_comb begin
        w_hi_addr_calc = req_addr + DEPTH'(1);
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_word          <= 1'b0;
            r_hi_addr       <= '0;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= '0;
            r_mem_enable    <= 1'b0;
            r_mem_wr_enable <= 1'b0;
            r_mem_address   <= '0;
            r_mem_wr_data   <= '0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_word          <= w_word_next;
            r_hi_addr       <= w_hi_addr_next;
            r_req_ready     <= w_req_ready_next;
            r_rsp_valid     <= w_rsp_valid_next;
            r_rsp_data      <= w_rsp_data_next;
            r_mem_enable    <= w_mem_enable_next;
            r_mem_wr_enable <= w_mem_wr_enable_next;
            r_mem_address   <= w_mem_address_next;
            r_mem_wr_data   <= w_mem_wr_data_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_cnt_next           = r_cnt;
        w_word_next          = r_word;
        w_hi_addr_next       = r_hi_addr;
        w_req_ready_next     = r_req_ready;
        w_rsp_valid_next     = 1'b0;
        w_rsp_data_next      = r_rsp_data;
        w_mem_enable_next    = 1'b0;
        w_mem_wr_enable_next = 1'b0;
        w_mem_address_next   = r_mem_address;
        w_mem_wr_data_next   = r_mem_wr_data;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_req_ready_next   = 1'b0;
                    w_mem_enable_next  = 1'b1;
                    w_mem_address_next = req_addr;
                    if (req_write) begin
                        w_state_next         = WRITE;
                        w_mem_wr_enable_next = 1'b1;
                        w_mem_wr_data_next   = req_wdata;
                    end else begin
                        w_state_next   = RD_LO;
                        w_cnt_next     = LAT_LOAD;
                        w_word_next    = req_word;
                        w_hi_addr_next = w_hi_addr_calc;
                    end
                end
            end

            WRITE: begin
                w_state_next     = IDLE;
                w_req_ready_next = 1'b1;
            end

            // Counter reaches zero at E(L), so the capture lands on E(1+L).
            RD_LO: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CW'(1);
                end else begin
                    w_rsp_data_next[WIDTH-1:0] = mem_rd_data;
                    if (r_word) begin
                        w_state_next       = RD_HI;
                        w_cnt_next         = LAT_LOAD;
                        w_mem_enable_next  = 1'b1;
                        w_mem_address_next = r_hi_addr;
                    end else begin
                        w_state_next                     = IDLE;
                        w_rsp_data_next[2*WIDTH-1:WIDTH] = '0;
                        w_rsp_valid_next                 = 1'b1;
                        w_req_ready_next                 = 1'b1;
                    end
                end
            end

            RD_HI: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CW'(1);
                end else begin
                    w_state_next                     = IDLE;
                    w_rsp_data_next[2*WIDTH-1:WIDTH] = mem_rd_data;
                    w_rsp_valid_next                 = 1'b1;
                    w_req_ready_next                 = 1'b1;
                end
            end

            default: begin
                w_state_next     = IDLE;
                w_req_ready_next = 1'b1;
            end
        endcase
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign mem_enable    = r_mem_enable;
    assign mem_wr_enable = r_mem_wr_enable;
    assign mem_address   = r_mem_address;
    assign mem_wr_data   = r_mem_wr_data;

endmodule
